data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 10 +
 rtl/data_memory_ram.sv | 27 ++
 rtl/data_memory.sv | 67 ++++++
 tb/tb_data_memory.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared sizing constants for the circular data memory
package data_memory_pkg;

  localparam int WIDTH     = 128;
  localparam int DEPTH     = 16;
  localparam int LANE_W    = 16;
  localparam int NUM_LANES = WIDTH / LANE_W;
  localparam int PTR_W     = $clog2(DEPTH);

endpackage

// File: rtl/data_memory_ram.sv
// rtl/data_memory_ram.sv - single-clock storage array, one write port, one registered read port
module data_memory_ram #(
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [2**AW];

  // Array write and registered read; q only moves when a read is requested
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - circular buffer of words with registered read and overwrite-oldest on full
module data_memory #(
  parameter int WIDTH = data_memory_pkg::WIDTH,
  parameter int DEPTH = data_memory_pkg::DEPTH
) (
  input  logic             wrclk,
  input  logic             wd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rd,
  input  logic             rst
);

  import data_memory_pkg::*;

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             rd_valid;
  logic             ram_we;
  logic             ram_re;
  logic [WIDTH-1:0] ram_q;

  // Reset wins over any access, so the array is never touched in a reset cycle
  assign ram_we = !rst && wd;
  assign ram_re = !rst && !wd && (cnt != '0);

  data_memory_ram #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk   (wrclk),
    .we    (ram_we),
    .waddr (wp),
    .wdata (data),
    .re    (ram_re),
    .raddr (rp),
    .q     (ram_q)
  );

  // Pointer and occupancy bookkeeping; rd_valid marks that ram_q holds a word read since reset
  always_ff @(posedge wrclk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else if (wd) begin
      wp <= wp + 1'b1;
      if (cnt == FULL) begin
        rp <= rp + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (cnt != '0) begin
      rp       <= rp + 1'b1;
      cnt      <= cnt - 1'b1;
      rd_valid <= 1'b1;
    end
  end

  // The RAM output register has no reset, so it is masked to zero until the first read
  assign rd = rd_valid ? ram_q : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed self-checking bench for data_memory
module tb_data_memory;

  localparam int W = 128;
  localparam int D = 16;

  logic         wrclk = 1'b0;
  logic         wd    = 1'b0;
  logic [W-1:0] data  = '0;
  logic [W-1:0] rd;
  logic         rst   = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] word_a;
  logic [W-1:0] word_b;

  data_memory #(.WIDTH(W), .DEPTH(D)) dut (
    .wrclk (wrclk),
    .wd    (wd),
    .data  (data),
    .rd    (rd),
    .rst   (rst)
  );

  always #5 wrclk = ~wrclk;

  task automatic step();
    @(posedge wrclk);
    #1;
  endtask

  task automatic do_write(input logic [W-1:0] v);
    wd   = 1'b1;
    data = v;
    step();
    wd   = 1'b0;
  endtask

  task automatic do_read();
    wd = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (rd === exp) else begin
      errors++;
      $error("FAIL %s: rd=%h expected %h", tag, rd, exp);
    end
  endtask

  function automatic logic [W-1:0] pat(input int i);
    logic [15:0] l;
    l = 16'(i) ^ 16'h5A00;
    return {l, ~l, l + 16'd1, l, 16'(i), l ^ 16'hFFFF, l, 16'(i * 3)};
  endfunction

  initial begin
    // reset and empty hold
    do_reset();
    check("reset_rd", '0);
    do_read();
    check("empty_read0", '0);
    do_read();
    check("empty_read1", '0);

    // two writes, two reads
    do_write('0);
    do_write(128'h000C000F00050001000B00030008000A);
    check("rd_hold_on_write", '0);
    do_read();
    check("first_read_zero", '0);
    do_read();
    check("second_read", 128'h000C000F00050001000B00030008000A);
    checks++;
    assert (rd[15:0] === 16'h000A) else begin
      errors++;
      $error("FAIL lane0: rd[15:0]=%h expected 000a", rd[15:0]);
    end

    // overwrite oldest when full
    do_reset();
    check("reset_after_data", '0);
    for (int i = 0; i <= D; i++) do_write(W'(i));
    for (int i = 1; i <= D; i++) begin
      do_read();
      check($sformatf("overwrite_read_%0d", i), W'(i));
    end
    do_read();
    check("empty_after_drain", W'(D));
    do_write(W'(99));
    check("hold_on_write_after_drain", W'(D));

    // reset discards unread words
    do_reset();
    do_write(W'(7));
    do_write(W'(8));
    do_write(W'(9));
    do_reset();
    do_read();
    check("reset_discards", '0);

    // reset with wd=1 in the same cycle: no write happens
    rst = 1'b1;
    wd  = 1'b1;
    data = W'(55);
    step();
    rst = 1'b0;
    wd  = 1'b0;
    do_read();
    check("reset_priority", '0);

    // interleaved access
    word_a = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF;
    word_b = 128'h0F0F_F0F0_AAAA_5555_1234_8765_CAFE_F00D;
    do_write(word_a);
    do_read();
    check("interleave_a", word_a);
    do_write(word_b);
    check("interleave_hold_a", word_a);
    do_read();
    check("interleave_b", word_b);
    do_read();
    check("interleave_b_held", word_b);

    // wrap-around from a non-zero pointer position
    do_reset();
    do_write(W'(1));
    do_write(W'(2));
    do_read();
    do_read();
    check("prewrap", W'(2));
    for (int i = 0; i < D; i++) do_write(pat(i));
    for (int i = 0; i < D; i++) begin
      do_read();
      check($sformatf("wrap_read_%0d", i), pat(i));
    end
    do_write(pat(100));
    do_write(pat(101));
    do_read();
    check("wrap_extra_0", pat(100));
    do_read();
    check("wrap_extra_1", pat(101));
    do_read();
    check("wrap_empty_hold", pat(101));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
